// File: rtl/scope_frame_uart_tx.sv
// Multi-channel ADC snapshot framer: on each sample event captures all channels plus the
// enable mask and sends HEADER, mask, enabled samples and a checksum over an 8N1 UART.
module scope_frame_uart_tx #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SAMPLE_PERIOD = 50_000_000,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_CH*8-1:0] Data,
    input  logic [NUM_CH-1:0]   Ch_en,
    input  logic                Trig,
    input  logic                Clr_ovr,
    output logic                uart_tx,
    output logic                Busy,
    output logic                Frame_done,
    output logic                Overrun,
    output logic                Led
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam int unsigned BW       = $clog2(BAUD_DIV + 1);
    localparam int unsigned SW       = $clog2(SAMPLE_PERIOD);
    localparam int unsigned CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
    typedef enum logic [1:0] {SeqHdr, SeqMask, SeqSamp, SeqCsum} seq_e;

    state_e              state_q, state_d;
    seq_e                seq_q, seq_d;
    logic [SW-1:0]       samp_cnt_q, samp_cnt_d;
    logic [BW-1:0]       baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          csum_q, csum_d;
    logic [NUM_CH*8-1:0] data_q, data_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic                tx_q, tx_d;
    logic                done_q, done_d;
    logic                ovr_q, ovr_d;
    logic                led_q, led_d;

    logic          sample_evt;
    logic          accept;
    logic          bit_end;
    logic          next_found;
    logic [CW-1:0] next_ch;
    logic [7:0]    mask_byte;
    logic [7:0]    next_samp;

    // Lowest enabled channel after the one just sent (or from 0 right after the mask byte).
    always_comb begin
        next_found = 1'b0;
        next_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!next_found && mask_q[i] && (seq_q == SeqMask || i > int'(ch_q))) begin
                next_found = 1'b1;
                next_ch    = CW'(i);
            end
        end
    end

    always_comb begin
        mask_byte               = '0;
        mask_byte[NUM_CH-1:0]   = mask_q;
        next_samp               = data_q[{next_ch, 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        data_d     = data_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        ovr_d      = ovr_q;
        led_d      = led_q;

        samp_cnt_d = (samp_cnt_q == SW'(SAMPLE_PERIOD - 1)) ? '0 : samp_cnt_q + 1'b1;
        sample_evt = Trig || (samp_cnt_q == SW'(SAMPLE_PERIOD - 1));
        // The Frame_done cycle still counts as busy, so no frame starts there.
        accept     = sample_evt && (state_q == StIdle) && !done_q;

        if (sample_evt && !accept) begin
            ovr_d = 1'b1;
        end else if (Clr_ovr) begin
            ovr_d = 1'b0;
        end

        bit_end    = (baud_cnt_q == BW'(BAUD_DIV - 1));
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                if (accept) begin
                    data_d  = Data;
                    mask_d  = Ch_en;
                    state_d = StStart;
                    seq_d   = SeqHdr;
                    shift_d = HEADER;
                    csum_d  = '0;
                    ch_d    = '0;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (seq_q == SeqCsum) begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        led_d   = ~led_q;
                    end else begin
                        state_d = StStart;
                        tx_d    = 1'b0;
                        case (seq_q)
                            SeqHdr: begin
                                seq_d   = SeqMask;
                                shift_d = mask_byte;
                                csum_d  = mask_byte;
                            end
                            SeqMask, SeqSamp: begin
                                if (next_found) begin
                                    seq_d   = SeqSamp;
                                    ch_d    = next_ch;
                                    shift_d = next_samp;
                                    csum_d  = csum_q + next_samp;
                                end else begin
                                    seq_d   = SeqCsum;
                                    shift_d = csum_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            seq_q      <= SeqHdr;
            samp_cnt_q <= '0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            ch_q       <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            samp_cnt_q <= samp_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            ch_q       <= ch_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            led_q      <= led_d;
        end
    end

    assign uart_tx    = tx_q;
    assign Busy       = (state_q != StIdle);
    assign Frame_done = done_q;
    assign Overrun    = ovr_q;
    assign Led        = led_q;

endmodule

// File: doc/scope_frame_uart_tx.md
Name: scope_frame_uart_tx

Overview:
Multi-channel successor to the single-channel ADC-to-UART sender. On each sample event it snapshots NUM_CH 8-bit ADC channels and a channel-enable mask together. It then transmits one framed packet over an 8N1 UART: header, mask, the enabled samples, and a checksum. It sits between the ADC capture registers and the board UART pin, and adds busy/overrun reporting and a frame-done pulse.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, integer division
NUM_CH, 4, number of ADC channels; legal range 1..8
SAMPLE_PERIOD, 50_000_000, clock cycles between automatic sample ticks; must be ≥ 2
HEADER, 8'hA5, frame sync byte

Ports:
Clk  input  1  system clock
Reset  input  1  one clock; reset is synchronous and active-high
Data  input  NUM_CH*8  channel samples; channel i is Data[8i+7:8i]
Ch_en  input  NUM_CH  channel enable mask; bit i enables channel i
Trig  input  1  manual sample request, one-cycle pulse, synchronous to Clk
Clr_ovr  input  1  clears the Overrun flag
uart_tx  output  1  serial output, idle high
Busy  output  1  high while a frame is in flight
Frame_done  output  1  one-cycle pulse at the end of each frame
Overrun  output  1  sticky flag: a sample event arrived while Busy
Led  output  1  toggles once per completed frame

Behaviour:
- Reset values: uart_tx=1, Busy=0, Frame_done=0, Overrun=0, Led=0. All counters, the FSM and the snapshot registers are cleared.
- Sample counter: free-running from 0 to SAMPLE_PERIOD-1, then wraps. It is independent of Busy.
- Sample event: the counter is at its terminal count, or Trig=1. Both in the same cycle count as a single event.
- Event while idle (Busy=0), at edge k:
  - Data and Ch_en are registered.
  - Busy=1 from k+1.
  - uart_tx goes low (start bit of the header byte) from k+1.
- Event while Busy=1: the frame in flight is unaffected and the event is dropped. Overrun is set at the next edge.
- Clr_ovr clears Overrun at the next edge. If an overrun and Clr_ovr occur in the same cycle, set wins.
- Frame byte order:
  - HEADER
  - mask byte: the Ch_en snapshot, zero-extended to 8 bits
  - the snapshot sample of each enabled channel, in ascending channel index
  - checksum = (mask byte + all sent sample bytes) mod 256; HEADER is excluded
  - With mask = 0, the frame is HEADER, 00, 00.
- Byte serialisation:
  - Start bit (0), then 8 data bits LSB first, then stop bit (1).
  - Each bit is held exactly BAUD_DIV cycles, so one byte is 10*BAUD_DIV cycles.
  - Bytes are sent back-to-back with no idle gap.
  - uart_tx is registered.
- FSM states: IDLE, START, DATA, STOP, with a byte-sequencer field that takes the values HDR, MASK, SAMP, CSUM.
  - STOP at the last bit cycle with more bytes pending → START of the next byte.
  - STOP at the last bit cycle after CSUM → IDLE.
  - SAMP skips disabled channels with no cycle penalty. The next enabled index is resolved combinationally or during the STOP bit.
- Frame end:
  - Frame length is (3+E)*10*BAUD_DIV cycles, where E is the number of enabled channels in the snapshot.
  - At the edge ending the CSUM stop bit: Busy→0, Frame_done=1 for one cycle, Led toggles.
  - A sample event in that same cycle counts as Busy (dropped, sets Overrun).
  - The earliest next frame can start one cycle after Busy falls.
- Snapshot isolation: changes on Data and Ch_en during a frame do not affect the frame.
- Reset mid-frame: at the next edge uart_tx=1, Busy=0, and the FSM returns to IDLE. No Frame_done pulse is generated and Led returns to 0.
- Checksum accumulator: 8 bits, wrapping, updated as each byte is loaded.

Test Plan:
Common bench setup: CLK_FREQ=1000, BAUD=100 (BAUD_DIV=10), NUM_CH=4, SAMPLE_PERIOD=100000. Decode uart_tx bit by bit.
1. Ch_en=4'hF, Data=32'h04030201, Trig pulse → bytes A5 0F 01 02 03 04 19. Busy high for 700 cycles. Frame_done pulses once. Led=1.
2. Ch_en=4'b0101, same Data → bytes A5 05 01 03 09. Frame length 500 cycles.
3. Ch_en=0, Trig pulse → bytes A5 00 00 (300 cycles). Then Data all 8'hFF with Ch_en=4'hF → checksum byte 0x0B (wrap check).
4. Trig pulse at cycle 150 of a running frame → frame bytes unchanged and Overrun=1. Clr_ovr pulse → Overrun=0. Clr_ovr together with a new overrun → Overrun stays 1.
5. Change Data and Ch_en in the middle of the frame from case 1 → transmitted bytes still match the snapshot. A Trig on the cycle Frame_done is high sets Overrun and starts no frame.
6. Reset asserted in the middle of the DATA state → next cycle uart_tx=1, Busy=0, Led=0, with no Frame_done pulse. A subsequent Trig produces a clean, complete frame.
